ext_interrupt_ctrl: RTL

//  External interrupt controller (EIC) feeding the core interrupt unit.
//  - Captures rising edges on N_SRC interrupt lines into pending bits.
//  - Selects the highest-priority unmasked pending source.
//  - Presents it to the core as a level request plus source ID.
//  - Retires the request when the core's toggle-style acknowledge changes.
//  - Sits between peripheral IRQ lines and the core-side request/ID/ack triple.

---
 rtl/ext_interrupt_ctrl_pkg.sv | 23 ++
 rtl/ext_interrupt_ctrl_int_prio_encoder.sv | 33 +++
 rtl/ext_interrupt_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ext_interrupt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ext_interrupt_ctrl_pkg
// Shared definitions for the external interrupt controller: controller state
// encoding, boolean constants and a sizing helper for the gap counter.
// ---------------------------------------------------------------------------
package ext_interrupt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_GAP   = 2'd3
  } eic_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Width of a down-counter that must hold min_low-1.
  function automatic int gap_cnt_w(input int min_low);
    return (min_low > 1) ? $clog2(min_low) : 1;
  endfunction

endpackage

// File: rtl/ext_interrupt_ctrl_int_prio_encoder.sv
// ---------------------------------------------------------------------------
// int_prio_encoder
// Fixed-priority encoder: returns the index of the lowest set bit of the
// request vector (index 0 = highest priority) plus a valid flag.
// Ports:
//   req_vec   in   N_SRC  candidate request bits
//   req_idx   out  ID_W   index of the winning request (0 when none)
//   req_valid out  1      at least one request bit is set
// ---------------------------------------------------------------------------
module int_prio_encoder
  import ext_interrupt_ctrl_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_vec,
  output logic [ID_W-1:0]  req_idx,
  output logic             req_valid
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    req_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        req_idx = ID_W'(i);
      end
    end
  end

  assign req_valid = (req_vec != '0) ? TRUE : FALSE;

endmodule

// File: rtl/ext_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// ext_interrupt_ctrl
// External interrupt controller. Latches rising edges of the source lines
// into pending bits, dispatches the highest-priority unmasked pending source
// to the core as a level request plus ID, and retires it when the core's
// toggle-style acknowledge changes. A minimum low time is enforced on the
// request line between consecutive requests.
// Ports:
//   Sys_Clock  in   1      system clock, all logic on rising edge
//   Sys_Reset  in   1      synchronous active-low reset
//   Irq_Src    in   N_SRC  source lines (edge-triggered, clock-synchronous)
//   Irq_Mask   in   N_SRC  1 = source masked (edges still latched)
//   Int_Ack    in   1      core acknowledge, one toggle per request, async
//   Int_Req    out  1      registered request level to the core
//   Int_Id     out  ID_W   dispatched source ID, stable while Int_Req=1
//   Pending    out  N_SRC  pending-bit status
//   Busy       out  1      controller is not idle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for an unmasked pending source; winner latched to ID
// ST_SETUP | one cycle of ID setup with the request still low
// ST_REQ   | request high until an acknowledge toggle is seen
// ST_GAP   | request held low for MIN_LOW cycles before the next dispatch
// ---------------------------------------------------------------------------
module ext_interrupt_ctrl
  import ext_interrupt_ctrl_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int ID_W    = $clog2(N_SRC),
  parameter int MIN_LOW = 4
) (
  input  logic             Sys_Clock,
  input  logic             Sys_Reset,
  input  logic [N_SRC-1:0] Irq_Src,
  input  logic [N_SRC-1:0] Irq_Mask,
  input  logic             Int_Ack,
  output logic             Int_Req,
  output logic [ID_W-1:0]  Int_Id,
  output logic [N_SRC-1:0] Pending,
  output logic             Busy
);

  localparam int              CNT_W    = gap_cnt_w(MIN_LOW);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_LOW - 1);

  eic_state_e       state_q, state_d;
  logic [N_SRC-1:0] src_prev_q, src_prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             ack_meta_q, ack_meta_d;
  logic             ack_s_q, ack_s_d;
  logic             ack_last_q, ack_last_d;
  logic             req_q, req_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_SRC-1:0] src_rise;
  logic [N_SRC-1:0] cand_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  win_idx;
  logic             win_valid;
  logic             ack_evt;

  assign cand_vec = pending_q & ~Irq_Mask;

  int_prio_encoder #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .req_vec   (cand_vec),
    .req_idx   (win_idx),
    .req_valid (win_valid)
  );

  always_comb begin
    src_rise   = Irq_Src & ~src_prev_q;
    src_prev_d = Irq_Src;

    ack_meta_d = Int_Ack;
    ack_s_d    = ack_meta_q;
    ack_last_d = ack_s_q;
    // ack_last tracks every cycle, so a toggle seen outside ST_REQ is
    // consumed and cannot retire a later request.
    ack_evt    = ack_s_q ^ ack_last_q;

    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    clr_vec = '0;

    case (state_q)
      ST_IDLE: begin
        req_d = FALSE;
        if (win_valid) begin
          id_d    = win_idx;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        req_d   = FALSE;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ack_evt) begin
          clr_vec[id_q] = TRUE;
          req_d         = FALSE;
          cnt_d         = GAP_LOAD;
          state_d       = ST_GAP;
        end else begin
          req_d = TRUE;
        end
      end
      ST_GAP: begin
        req_d = FALSE;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        req_d   = FALSE;
        state_d = ST_IDLE;
      end
    endcase

    // A new edge on the source being retired wins over the clear.
    pending_d = (pending_q & ~clr_vec) | src_rise;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge Sys_Clock) begin
    if (!Sys_Reset) begin
      state_q    <= ST_IDLE;
      src_prev_q <= Irq_Src;
      pending_q  <= '0;
      ack_meta_q <= FALSE;
      ack_s_q    <= FALSE;
      ack_last_q <= FALSE;
      req_q      <= FALSE;
      id_q       <= '0;
      busy_q     <= FALSE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src_prev_d;
      pending_q  <= pending_d;
      ack_meta_q <= ack_meta_d;
      ack_s_q    <= ack_s_d;
      ack_last_q <= ack_last_d;
      req_q      <= req_d;
      id_q       <= id_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Int_Req = req_q;
  assign Int_Id  = id_q;
  assign Pending = pending_q;
  assign Busy    = busy_q;

endmodule
